// File: rtl/soc_onchip_memory_arbiter.sv
// Shares the single port of the on-chip RAM between two Avalon-MM masters with round-robin
// arbitration, after zero-filling the whole RAM following reset.
module soc_onchip_memory_arbiter #(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 1024,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    input  logic [DATA_W-1:0]     mem_readdata,
    output logic                  init_done
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam state_t              RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
    localparam logic                RESET_DONE  = (CLEAR_ON_RESET == 0);
    localparam logic [ADDR_W-1:0]   LAST_ADDR   = ADDR_W'(DEPTH - 1);

    state_t             r_state;
    state_t             w_stateNext;
    logic [ADDR_W-1:0]  r_count;
    logic               r_initDone;
    logic               r_lastGrant;
    logic               r_rdPend;
    logic               r_rdOwner;
    logic               w_req0;
    logic               w_req1;
    logic               w_grant0;
    logic               w_grant1;
    logic               w_rdAccept;

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // A simultaneous read+write is served as a write, so it never raises a read return.
    assign w_rdAccept = (w_grant0 & m0_read & ~m0_write) | (w_grant1 & m1_read & ~m1_write);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count     <= '0;
            r_initDone  <= RESET_DONE;
            r_lastGrant <= 1'b1;
            r_rdPend    <= 1'b0;
            r_rdOwner   <= 1'b0;
        end else begin
            if (r_state == ST_INIT) begin
                if (r_count == LAST_ADDR) begin
                    r_initDone <= 1'b1;
                end else begin
                    r_count <= r_count + ADDR_W'(1);
                end
            end
            if (w_grant0 | w_grant1) begin
                r_lastGrant <= w_grant1;
            end
            r_rdPend <= w_rdAccept;
            if (w_rdAccept) begin
                r_rdOwner <= w_grant1;
            end
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_grant0       = 1'b0;
        w_grant1       = 1'b0;
        mem_address    = '0;
        mem_byteenable = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = '0;
        case (r_state)
            ST_INIT: begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_byteenable = '1;
                mem_address    = r_count;
                if (r_count == LAST_ADDR) begin
                    w_stateNext = ST_RUN;
                end
            end
            ST_RUN: begin
                // On a tie the master that did not win last time goes first.
                w_grant0 = w_req0 & (~w_req1 | r_lastGrant);
                w_grant1 = w_req1 & ~w_grant0;
                if (w_grant1) begin
                    mem_chipselect = 1'b1;
                    mem_write      = m1_write;
                    mem_address    = m1_address;
                    mem_byteenable = m1_byteenable;
                    mem_writedata  = m1_writedata;
                end else if (w_grant0) begin
                    mem_chipselect = 1'b1;
                    mem_write      = m0_write;
                    mem_address    = m0_address;
                    mem_byteenable = m0_byteenable;
                    mem_writedata  = m0_writedata;
                end
            end
            default: begin
                w_stateNext = RESET_STATE;
            end
        endcase
    end

    // Gating with reset_n keeps both masters stalled while reset is held, even with no fill.
    assign m0_waitrequest   = ~(reset_n & w_grant0);
    assign m1_waitrequest   = ~(reset_n & w_grant1);
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = r_rdPend & ~r_rdOwner;
    assign m1_readdatavalid = r_rdPend & r_rdOwner;
    assign init_done        = r_initDone;

endmodule

// File: tb/tb_soc_onchip_memory_arbiter.sv
// Directed self-checking bench for soc_onchip_memory_arbiter with a behavioural 1024x32 RAM
// (registered address, unregistered output) attached to the mem_* port.
module tb_soc_onchip_memory_arbiter;

    logic        clk;
    logic        reset_n;
    logic [9:0]  m0_address;
    logic [3:0]  m0_byteenable;
    logic        m0_read;
    logic        m0_write;
    logic [31:0] m0_writedata;
    logic        m0_waitrequest;
    logic [31:0] m0_readdata;
    logic        m0_readdatavalid;
    logic [9:0]  m1_address;
    logic [3:0]  m1_byteenable;
    logic        m1_read;
    logic        m1_write;
    logic [31:0] m1_writedata;
    logic        m1_waitrequest;
    logic [31:0] m1_readdata;
    logic        m1_readdatavalid;
    logic [9:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        init_done;

    int checkCount = 0;
    int passCount  = 0;

    soc_onchip_memory_arbiter dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_readdata     (mem_readdata),
        .init_done        (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model; seeded with a non-zero pattern so the zero-fill is observable.
    logic [31:0] ram [0:1023];
    logic [9:0]  ramAddrQ = '0;
    logic        ramSeeded = 1'b0;

    always @(posedge clk) begin
        if (!ramSeeded) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 32'hA5A5_A5A5;
            ramSeeded <= 1'b1;
        end else if (mem_chipselect && mem_write) begin
            for (int b = 0; b < 4; b++)
                if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
        ramAddrQ <= mem_address;
    end
    assign mem_readdata = ram[ramAddrQ];

    always @(posedge clk) begin
        if (reset_n) begin
            assert (!(m0_read && m0_write)) else $error("[TB] illegal m0 read+write together");
            assert (!(m1_read && m1_write)) else $error("[TB] illegal m1 read+write together");
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    // Checks one full zero-fill starting in the current cycle, then the first RUN cycle.
    task runFill(input string name);
        int bad = 0;
        int firstBad = -1;
        int firstAddr = 0;
        for (int i = 0; i < 1024; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (mem_address !== 10'(i) || mem_write !== 1'b1 || mem_chipselect !== 1'b1 ||
                mem_byteenable !== 4'hF || mem_writedata !== 32'h0 || init_done !== 1'b0 ||
                m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1 ||
                m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
                if (bad == 0) begin
                    firstBad  = i;
                    firstAddr = int'(mem_address);
                end
                bad++;
            end
        end
        checkCount++;
        if (bad != 0)
            $display("[TB] FAIL %s: %0d bad fill cycles (first at cycle %0d, addr %0d), required 0", name, bad, firstBad, firstAddr);
        else passCount++;
        @(negedge clk); #1;
        checkCount++;
        if (init_done !== 1'b1) $display("[TB] FAIL %s_done: init_done=%b required 1 at cycle 1024", name, init_done);
        else passCount++;
    endtask

    task test_reset;
        reset_n = 1'b0;
        m0_address = 10'd3; m0_byteenable = 4'hF; m0_read = 1'b1; m0_write = 1'b0; m0_writedata = '0;
        m1_address = 10'd0; m1_byteenable = 4'hF; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0;
        repeat (3) @(negedge clk);
        #1;
        checkCount++;
        if ({m0_waitrequest, m1_waitrequest} !== 2'b11) $display("[TB] FAIL reset_wait: got %b required 11", {m0_waitrequest, m1_waitrequest});
        else passCount++;
        checkCount++;
        if (init_done !== 1'b0) $display("[TB] FAIL reset_init_done: got %b required 0", init_done);
        else passCount++;
        checkCount++;
        if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) $display("[TB] FAIL reset_rdv: got %b required 00", {m0_readdatavalid, m1_readdatavalid});
        else passCount++;
        @(negedge clk);
        reset_n = 1'b1;
        runFill("fill_initial");
        checkCount++;
        if (m0_waitrequest !== 1'b0 || mem_chipselect !== 1'b1 || mem_write !== 1'b0 || mem_address !== 10'd3)
            $display("[TB] FAIL first_run_accept: wait=%b cs=%b wr=%b addr=%0d required 0 1 0 3", m0_waitrequest, mem_chipselect, mem_write, mem_address);
        else passCount++;
        @(negedge clk);
        m0_read = 1'b0;
        #1;
        checkCount++;
        if (m0_readdatavalid !== 1'b1 || m1_readdatavalid !== 1'b0 || m0_readdata !== 32'h0)
            $display("[TB] FAIL first_read_return: rdv0=%b rdv1=%b data=%h required 1 0 00000000", m0_readdatavalid, m1_readdatavalid, m0_readdata);
        else passCount++;
    endtask

    task test_write_read_m0;
        @(negedge clk);
        m0_address = 10'd5; m0_byteenable = 4'hF; m0_writedata = 32'hDEAD_BEEF; m0_write = 1'b1;
        #1;
        checkCount++;
        if (m0_waitrequest !== 1'b0 || mem_write !== 1'b1 || mem_address !== 10'd5 || mem_writedata !== 32'hDEAD_BEEF)
            $display("[TB] FAIL m0_write: wait=%b wr=%b addr=%0d data=%h required 0 1 5 deadbeef", m0_waitrequest, mem_write, mem_address, mem_writedata);
        else passCount++;
        @(negedge clk);
        m0_write = 1'b0; m0_read = 1'b1;
        #1;
        checkCount++;
        if (m0_waitrequest !== 1'b0 || m0_readdatavalid !== 1'b0)
            $display("[TB] FAIL m0_read_accept: wait=%b rdv=%b required 0 0", m0_waitrequest, m0_readdatavalid);
        else passCount++;
        @(negedge clk);
        m0_read = 1'b0;
        #1;
        checkCount++;
        if (m0_readdatavalid !== 1'b1 || m1_readdatavalid !== 1'b0 || m0_readdata !== 32'hDEAD_BEEF)
            $display("[TB] FAIL m0_read_data: rdv0=%b rdv1=%b data=%h required 1 0 deadbeef", m0_readdatavalid, m1_readdatavalid, m0_readdata);
        else passCount++;
        @(negedge clk); #1;
        checkCount++;
        if (m0_readdatavalid !== 1'b0) $display("[TB] FAIL m0_single_pulse: rdv0=%b required 0", m0_readdatavalid);
        else passCount++;
    endtask

    task test_byteenable_m1;
        @(negedge clk);
        m1_address = 10'd7; m1_byteenable = 4'b0011; m1_writedata = 32'h1122_3344; m1_write = 1'b1;
        #1;
        checkCount++;
        if (m1_waitrequest !== 1'b0 || m0_waitrequest !== 1'b1 || mem_byteenable !== 4'b0011)
            $display("[TB] FAIL m1_write: wait1=%b wait0=%b be=%b required 0 1 0011", m1_waitrequest, m0_waitrequest, mem_byteenable);
        else passCount++;
        @(negedge clk);
        m1_write = 1'b0; m1_read = 1'b1; m1_byteenable = 4'hF;
        @(negedge clk);
        m1_read = 1'b0;
        #1;
        checkCount++;
        if (m1_readdatavalid !== 1'b1 || m0_readdatavalid !== 1'b0 || m1_readdata !== 32'h0000_3344)
            $display("[TB] FAIL m1_partial_data: rdv1=%b rdv0=%b data=%h required 1 0 00003344", m1_readdatavalid, m0_readdatavalid, m1_readdata);
        else passCount++;
    endtask

    task test_alternating;
        logic m1Prev;
        @(negedge clk);
        m0_address = 10'd1; m0_writedata = 32'h0000_0101; m0_byteenable = 4'hF; m0_write = 1'b1;
        @(negedge clk);
        m0_write = 1'b0;
        m1_address = 10'd2; m1_writedata = 32'h0000_0202; m1_byteenable = 4'hF; m1_write = 1'b1;
        @(negedge clk);
        m1_write = 1'b0;
        m0_read = 1'b1; m1_read = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            checkCount++;
            if (m0_waitrequest !== logic'(k % 2 == 1) || m1_waitrequest !== logic'(k % 2 == 0) || mem_address !== ((k % 2 == 0) ? 10'd1 : 10'd2))
                $display("[TB] FAIL alt_grant[%0d]: wait0=%b wait1=%b addr=%0d required %b %b %0d", k, m0_waitrequest, m1_waitrequest, mem_address, k % 2 == 1, k % 2 == 0, (k % 2 == 0) ? 1 : 2);
            else passCount++;
            if (k > 0) begin
                m1Prev = ((k - 1) % 2 == 1);
                checkCount++;
                if (m0_readdatavalid !== ~m1Prev || m1_readdatavalid !== m1Prev || m0_readdata !== (m1Prev ? 32'h202 : 32'h101))
                    $display("[TB] FAIL alt_return[%0d]: rdv0=%b rdv1=%b data=%h required %b %b %h", k, m0_readdatavalid, m1_readdatavalid, m0_readdata, ~m1Prev, m1Prev, m1Prev ? 32'h202 : 32'h101);
                else passCount++;
            end
        end
        @(negedge clk);
        m0_read = 1'b0; m1_read = 1'b0;
        #1;
        checkCount++;
        if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b1 || m1_readdata !== 32'h202)
            $display("[TB] FAIL alt_last_return: rdv0=%b rdv1=%b data=%h required 0 1 00000202", m0_readdatavalid, m1_readdatavalid, m1_readdata);
        else passCount++;
    endtask

    task test_back_to_back;
        logic [9:0]  addrs [4];
        logic [31:0] exps  [4];
        addrs = '{10'd2, 10'd7, 10'd5, 10'd1};
        exps  = '{32'h0000_0202, 32'h0000_3344, 32'hDEAD_BEEF, 32'h0000_0101};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k < 4) begin
                m1_address = addrs[k]; m1_read = 1'b1;
            end else begin
                m1_read = 1'b0;
            end
            #1;
            if (k < 4) begin
                checkCount++;
                if (m1_waitrequest !== 1'b0) $display("[TB] FAIL b2b_wait[%0d]: wait1=%b required 0", k, m1_waitrequest);
                else passCount++;
            end
            if (k > 0 && k < 5) begin
                checkCount++;
                if (m1_readdatavalid !== 1'b1 || m1_readdata !== exps[k-1])
                    $display("[TB] FAIL b2b_return[%0d]: rdv1=%b data=%h required 1 %h", k, m1_readdatavalid, m1_readdata, exps[k-1]);
                else passCount++;
            end
            if (k == 5) begin
                checkCount++;
                if (m1_readdatavalid !== 1'b0) $display("[TB] FAIL b2b_end: rdv1=%b required 0", m1_readdatavalid);
                else passCount++;
            end
        end
    endtask

    task test_reset_during_read;
        @(negedge clk);
        m0_address = 10'd5; m0_read = 1'b1;
        #1;
        checkCount++;
        if (m0_waitrequest !== 1'b0) $display("[TB] FAIL rstrd_accept: wait0=%b required 0", m0_waitrequest);
        else passCount++;
        @(negedge clk);
        m0_read = 1'b0;
        #1;
        checkCount++;
        if (m0_readdatavalid !== 1'b1) $display("[TB] FAIL rstrd_pending: rdv0=%b required 1", m0_readdatavalid);
        else passCount++;
        reset_n = 1'b0;
        #1;
        checkCount++;
        if (m0_readdatavalid !== 1'b0 || init_done !== 1'b0 || {m0_waitrequest, m1_waitrequest} !== 2'b11 || mem_address !== 10'd0)
            $display("[TB] FAIL rstrd_drop: rdv0=%b done=%b wait=%b addr=%0d required 0 0 11 0", m0_readdatavalid, init_done, {m0_waitrequest, m1_waitrequest}, mem_address);
        else passCount++;
        @(negedge clk);
        reset_n = 1'b1;
        runFill("fill_after_read_reset");
    endtask

    task test_reset_midfill;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i <= 300; i++) begin
            if (i > 0) @(negedge clk);
            #1;
        end
        checkCount++;
        if (mem_address !== 10'd300 || init_done !== 1'b0)
            $display("[TB] FAIL midfill_pos: addr=%0d done=%b required 300 0", mem_address, init_done);
        else passCount++;
        reset_n = 1'b0;
        #1;
        checkCount++;
        if (mem_address !== 10'd0 || init_done !== 1'b0)
            $display("[TB] FAIL midfill_reset: addr=%0d done=%b required 0 0", mem_address, init_done);
        else passCount++;
        @(negedge clk);
        reset_n = 1'b1;
        runFill("fill_after_midfill_reset");
    endtask

    initial begin
        test_reset();
        test_write_read_m0();
        test_byteenable_m1();
        test_alternating();
        test_back_to_back();
        test_reset_during_read();
        test_reset_midfill();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/soc_onchip_memory_arbiter.md
Name: soc_onchip_memory_arbiter

Overview:
- Owns the single port of the 1024x32 on-chip RAM and shares it between two Avalon-MM masters (m0, m1) using round-robin arbitration.
- After reset it runs a zero-fill sequencer across the whole RAM, because the RAM has no init file. Masters are held off until the fill completes.
- Sits between the fabric-side masters and the RAM instance, which has a registered address and an unregistered output.

Parameters:
- ADDR_W, 10, word address width of RAM and master ports
- DATA_W, 32, data width; byteenable width BE_W = DATA_W/8
- DEPTH, 1024, number of words cleared; DEPTH <= 2**ADDR_W
- CLEAR_ON_RESET, 1, 1 = run zero-fill after reset; 0 = enter RUN directly

Ports:
- clk  in  1  single clock
- reset_n  in  1  asynchronous active-low reset
- m0_address  in  ADDR_W  master 0 word address
- m0_byteenable  in  BE_W  master 0 byte lanes
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_writedata  in  DATA_W  master 0 write data
- m0_waitrequest  out  1  master 0 stall
- m0_readdata  out  DATA_W  master 0 read data
- m0_readdatavalid  out  1  master 0 read data strobe
- m1_*  (same set as m0)  master 1
- mem_address  out  ADDR_W  RAM address
- mem_byteenable  out  BE_W  RAM byte enables
- mem_chipselect  out  1  RAM select
- mem_write  out  1  RAM write
- mem_writedata  out  DATA_W  RAM write data
- mem_readdata  in  DATA_W  RAM output, valid the cycle after the address
- init_done  out  1  zero-fill complete

Behaviour:
- Reset values, applied asynchronously on reset_n low:
  - FSM = INIT if CLEAR_ON_RESET, else RUN.
  - Fill counter = 0; last_grant = m1, so m0 wins the first tie.
  - m*_readdatavalid = 0; rd_pend = 0; rd_owner = 0.
  - init_done = 0 if CLEAR_ON_RESET, else 1.
  - Both waitrequest outputs = 1 while reset_n is low.
- INIT state:
  - Each cycle drive mem_chipselect=1, mem_write=1, mem_byteenable=all ones, mem_writedata=0, mem_address=counter.
  - Counter increments by 1 each cycle. When address DEPTH-1 is written, go to RUN and register init_done=1 in the same edge.
  - Fill takes exactly DEPTH cycles.
  - Both waitrequest outputs = 1 throughout INIT; no master access and no readdatavalid.
- RUN state, arbitration (combinational, same cycle):
  - req_i = m_i_read | m_i_write.
  - One requester: grant it.
  - Both requesting: grant the master that is not last_grant.
  - last_grant updates on every grant.
  - A master may be granted on consecutive cycles when the other is idle.
- RUN state, datapath:
  - mem_* signals are muxed combinationally from the granted master.
  - mem_chipselect = 1 only when a grant exists; mem_write = granted master's write.
  - Granted master sees waitrequest=0 that cycle; the other sees 1.
  - No grant: mem_chipselect=0, mem_write=0, address and data don't-care.
- Read return:
  - A granted read sets rd_pend=1 and rd_owner=grantee on the clock edge.
  - Next cycle: m[rd_owner]_readdatavalid=1.
  - Both m*_readdata are driven from mem_readdata; content is meaningful only while readdatavalid is high.
  - Read latency is fixed at 1 cycle after acceptance. Reads can be issued back-to-back, giving one result per cycle.
- Read and write asserted together by one master is an illegal Avalon access:
  - Treat it as a write; no readdatavalid follows.
  - The bench flags it with an assertion.
- Write-then-read to the same address on consecutive cycles returns the new data.
- Reset mid-operation:
  - Any cycle: pending readdatavalid is dropped.
  - Fill restarts at address 0; init_done falls immediately.
- The DEPTH counter never wraps; INIT is left exactly once per reset.

Test Plan:
- Release reset_n -> mem_write=1 with mem_address 0,1,...,1023 on 1024 consecutive cycles; init_done=1 from cycle 1024. An m0_read held from cycle 0 keeps waitrequest=1 until the first RUN cycle, then is accepted.
- After init, m0 writes 0xDEADBEEF at addr 5 with be=4'hF, then reads addr 5 -> m0_readdatavalid=1 exactly one cycle after acceptance, readdata=0xDEADBEEF.
- m1 writes 0x11223344 with be=4'b0011 to zeroed addr 7, then reads it -> 0x00003344.
- m0 and m1 both issue continuous reads (m0 addr 1, m1 addr 2) -> grants alternate m0,m1,m0,...; each waitrequest is low every other cycle; readdatavalid goes to the correct owner with 1-cycle latency.
- m1 alone issues 4 back-to-back reads -> waitrequest=0 on all 4 cycles; 4 readdatavalid pulses on consecutive cycles.
- Assert reset_n low while the fill counter is at 300, and separately one cycle after an accepted read -> no readdatavalid pulse; after release, the fill restarts at address 0 and init_done=0 until 1024 cycles later.
